iter_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor for the UART hex calculator datapath. It replaces the fixed 4-bit ripple-carry stage with a WIDTH-bit operation that is evaluated CHUNK bits per clock, with the carry held in a register between cycles. Operands arrive over a valid/ready handshake from the command parser. The result, carry/borrow and flags are returned over a second valid/ready handshake to the hex-to-ASCII formatter.

---
 rtl/iter_addsub_if.sv | 28 ++
 rtl/iter_addsub.sv | 101 ++++++++++
 tb/tb_iter_addsub.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/iter_addsub_if.sv
// Operand/result handshake bundle for the multi-cycle adder/subtractor.
// The slave modport is the arithmetic block's view, and the master modport is the parser/formatter side.
interface iter_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, a, b, sub, c_in, out_ready,
        output in_ready, out_valid, result, c_out, ovf, zero
    );

    modport master (
        output in_valid, a, b, sub, c_in, out_ready,
        input  in_ready, out_valid, result, c_out, ovf, zero
    );
endinterface

// File: rtl/iter_addsub.sv
// WIDTH-bit adder/subtractor evaluated CHUNK bits per clock, LSB chunk first.
// The carry is held in a register between cycles, and results are returned over a valid/ready handshake.
module iter_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    iter_addsub_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nx;
    logic             carry;
    logic             c_out_q;
    logic             ovf_q;
    logic             zero_q;
    logic [KW-1:0]    k;
    logic [CHUNK:0]   chunk_sum;
    logic             last;
    logic             accept;

    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (k == KW'(N - 1));

    // Current chunk sum, with the full result as it stands once this chunk is written.
    always_comb begin
        chunk_sum = chunk_add(a_q[int'(k) * CHUNK +: CHUNK], b_q[int'(k) * CHUNK +: CHUNK], carry);
        res_nx    = res_q;
        res_nx[int'(k) * CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Operand capture: B is pre-inverted so subtraction is A + ~B + 1.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= bus.a;
            b_q <= bus.sub ? ~bus.b : bus.b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            res_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            carry   <= 1'b0;
            k       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state <= CALC;
                        carry <= bus.sub | bus.c_in;
                        k     <= '0;
                    end
                end
                CALC: begin
                    res_q <= res_nx;
                    carry <= chunk_sum[CHUNK];
                    k     <= k + 1'b1;
                    if (last) begin
                        c_out_q <= chunk_sum[CHUNK];
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
                        zero_q  <= (res_nx == '0);
                        k       <= '0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_iter_addsub.sv
// Directed bench for iter_addsub at three parameter sets (16/4, 32/8, 8/1).
// A vector table drives the main operations, and hand-written sequences cover backpressure and mid-operation reset.
module tb_iter_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iter_addsub_if #(.WIDTH(16)) if16 ();
    iter_addsub_if #(.WIDTH(32)) if32 ();
    iter_addsub_if #(.WIDTH(8))  if8  ();

    iter_addsub #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    iter_addsub #(.WIDTH(32), .CHUNK(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    iter_addsub #(.WIDTH(8),  .CHUNK(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs[10];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cur    = 0;

    logic        o_v, o_rdy, o_co, o_ov, o_z;
    logic [31:0] o_res;

    always_comb begin
        case (cur)
            1: begin
                o_v = if32.out_valid; o_rdy = if32.in_ready; o_res = if32.result;
                o_co = if32.c_out; o_ov = if32.ovf; o_z = if32.zero;
            end
            2: begin
                o_v = if8.out_valid; o_rdy = if8.in_ready; o_res = {24'b0, if8.result};
                o_co = if8.c_out; o_ov = if8.ovf; o_z = if8.zero;
            end
            default: begin
                o_v = if16.out_valid; o_rdy = if16.in_ready; o_res = {16'b0, if16.result};
                o_co = if16.c_out; o_ov = if16.ovf; o_z = if16.zero;
            end
        endcase
    end

    function automatic int lat_of(input int s);
        return (s == 2) ? 8 : 4;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input int s, input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic sb, input logic ci);
        case (s)
            1: begin if32.in_valid = v; if32.a = av; if32.b = bv; if32.sub = sb; if32.c_in = ci; end
            2: begin if8.in_valid = v; if8.a = av[7:0]; if8.b = bv[7:0]; if8.sub = sb; if8.c_in = ci; end
            default: begin
                if16.in_valid = v; if16.a = av[15:0]; if16.b = bv[15:0]; if16.sub = sb; if16.c_in = ci;
            end
        endcase
    endtask

    task automatic set_ordy(input int s, input logic r);
        case (s)
            1: if32.out_ready = r;
            2: if8.out_ready = r;
            default: if16.out_ready = r;
        endcase
    endtask

    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sb, input logic ci);
        @(negedge clk);
        check("in_ready_before_accept", {31'b0, o_rdy}, 32'd1);
        drive(cur, 1'b1, av, bv, sb, ci);
        @(posedge clk);
        #1;
        drive(cur, 1'b0, ~av, ~bv, ~sb, ~ci);
    endtask

    task automatic wait_done(input int exp_lat);
        int lat;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (o_v) begin
                lat = c;
                break;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_out(input logic [31:0] res, input logic co, input logic ov, input logic z);
        check("result", o_res, res);
        check("c_out", {31'b0, o_co}, {31'b0, co});
        check("ovf", {31'b0, o_ov}, {31'b0, ov});
        check("zero", {31'b0, o_z}, {31'b0, z});
    endtask

    task automatic finish_op();
        @(negedge clk);
        set_ordy(cur, 1'b1);
        @(posedge clk);
        #1;
        check("in_ready_after_hs", {31'b0, o_rdy}, 32'd1);
        check("out_valid_after_hs", {31'b0, o_v}, 32'd0);
        set_ordy(cur, 1'b0);
    endtask

    initial begin
        vecs[0] = '{0, 32'h1234,     32'h0FFF,     1'b0, 1'b0, 32'h2233,     1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 32'hFFFF,     32'h0001,     1'b0, 1'b0, 32'h0000,     1'b1, 1'b0, 1'b1};
        vecs[2] = '{0, 32'h7FFF,     32'h0000,     1'b0, 1'b1, 32'h8000,     1'b0, 1'b1, 1'b0};
        vecs[3] = '{0, 32'h8000,     32'h0001,     1'b1, 1'b1, 32'h7FFF,     1'b1, 1'b1, 1'b0};
        vecs[4] = '{0, 32'h0003,     32'h0005,     1'b1, 1'b1, 32'hFFFE,     1'b0, 1'b0, 1'b0};
        vecs[5] = '{0, 32'h1234,     32'h1234,     1'b1, 1'b0, 32'h0000,     1'b1, 1'b0, 1'b1};
        vecs[6] = '{1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{2, 32'hFF,       32'h01,       1'b0, 1'b0, 32'h00,       1'b1, 1'b0, 1'b1};
        vecs[8] = '{2, 32'h80,       32'h01,       1'b1, 1'b0, 32'h7F,       1'b1, 1'b1, 1'b0};
        vecs[9] = '{1, 32'h00000005, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000005, 1'b1, 1'b0, 1'b0};

        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            set_ordy(s, 1'b0);
        end

        // Reset state
        #12;
        cur = 0;
        #1;
        check("rst_in_ready", {31'b0, o_rdy}, 32'd1);
        check("rst_out_valid", {31'b0, o_v}, 32'd0);
        check_out(32'h0, 1'b0, 1'b0, 1'b0);
        cur = 2;
        #1;
        check("rst_in_ready_w8", {31'b0, o_rdy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cur = vecs[i].sel;
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            wait_done(lat_of(cur));
            check_out(vecs[i].res, vecs[i].co, vecs[i].ov, vecs[i].z);
            finish_op();
        end

        // Backpressure: DONE holds while out_ready is low and inputs wiggle
        cur = 0;
        start_op(32'h1234, 32'h0FFF, 1'b0, 1'b0);
        wait_done(4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(cur, c[0], $urandom, $urandom, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'b0, o_v}, 32'd1);
            check("bp_in_ready", {31'b0, o_rdy}, 32'd0);
            check("bp_result", o_res, 32'h2233);
        end
        check_out(32'h2233, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(cur, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        finish_op();

        // Asynchronous reset two CALC cycles into an operation
        cur = 0;
        start_op(32'hFFFF, 32'h0001, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'b0, o_rdy}, 32'd1);
        check("midrst_out_valid", {31'b0, o_v}, 32'd0);
        check_out(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(32'h0001, 32'h0001, 1'b0, 1'b0);
        wait_done(4);
        check_out(32'h0002, 1'b0, 1'b0, 1'b0);
        finish_op();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
